sata_crc_checker: RTL
=====================

// Module: sata_crc_checker
// PURPOSE
//  Receive-side CRC checker for SerialATA frames: inbound dword stream carries the frame CRC as its final (eop) dword.
//  Strips the CRC dword, forwards payload dwords downstream, and flags a CRC mismatch alongside the last payload dword.
//  Sits between the link-layer descrambler output and the transport-layer receive FIFO; instantiates crc_calculator.
// PARAMETERS
//  POLYNOMIAL   `CRC_POLYNOMIAL  generator polynomial passed to crc_calculator (32 bit)
//  INITVALUE    `CRC_INITVALUE   CRC seed loaded at reset and at every frame start
// PORTS
//  clk      in   1   clock; all logic in this single domain
//  reset_n  in   1   asynchronous reset, active low
//  i_dat    in   32  inbound dword (payload, or CRC when i_eop=1)
//  i_val    in   1   inbound dword valid
//  i_eop    in   1   inbound dword is the frame CRC (last dword)
//  i_rdy    out  1   inbound ready; transfer when i_val & i_rdy
//  o_dat    out  32  payload dword
//  o_val    out  1   payload valid
//  o_eop    out  1   last payload dword of frame
//  o_err    out  1   CRC mismatch; meaningful only with o_val & o_eop
//  o_rdy    in   1   downstream ready; transfer when o_val & o_rdy
//  runt     out  1   1-cycle pulse: frame with no payload (lone eop dword) discarded
//  err_cnt  out  16  count of frames ended with o_err=1 (see CONFIGURATION)
// BEHAVIOUR
//  State: hold register {hold_val, hold_dat, hold_eop, hold_err}, crc_reg; crc_new = crc_calculator(hold_dat, crc_reg).
//  Reset (reset_n=0, async): hold_val=0, hold_eop=0, hold_err=0, crc_reg=INITVALUE, runt=0, err_cnt=0.
//   Outputs in reset: o_val=0, o_eop=0, o_err=0, i_rdy=1. Reset mid-frame drops partial frame, no output.
//  o_dat=hold_dat; o_eop=hold_eop; o_err=hold_err.
//  EMPTY (hold_val=0): i_rdy=1, o_val=0.
//   accept i_eop=0 -> hold_dat<=i_dat, hold_val<=1.
//   accept i_eop=1 -> dword discarded, runt pulses next cycle, crc_reg stays INITVALUE.
//  HOLD (hold_val=1, hold_eop=0): held dword is released only when its successor is known.
//   o_val = i_val & ~i_eop; i_rdy = i_eop ? 1 : o_rdy.
//   i_val&~i_eop&o_rdy -> emit hold (o_eop=0); crc_reg<=crc_new; hold_dat<=i_dat.
//   i_val&i_eop -> no emit this cycle; hold_eop<=1; hold_err<=(crc_new!=i_dat); crc_reg<=INITVALUE.
//   i_val=0 -> hold unchanged (no timeout).
//  LAST (hold_val=1, hold_eop=1): o_val=1, o_eop=1, i_rdy=0.
//   o_rdy=1 -> hold_val<=0, hold_eop<=0, hold_err<=0; next cycle EMPTY.
//  Latency: payload dword N appears once dword N+1 is presented; last payload 1 cycle after CRC dword accepted.
//  Inter-frame: >=1 cycle with i_rdy=0 (LAST state); back-to-back frames otherwise stall-free.
//  o_dat/o_eop/o_err stable while o_val=1 and o_rdy=0. CRC compare is full 32-bit equality, no bit reversal.
// CONFIGURATION
//  SATA_CRC_ERRCNT_EN defined: err_cnt increments (saturating at 0xFFFF) on each o_val&o_rdy&o_eop&o_err;
//   cleared only by reset_n.
//  SATA_CRC_ERRCNT_EN undefined: err_cnt tied to 16'h0000; no counter logic; all other behaviour identical.
// TESTING
//  Golden CRC from a crc_calculator model seeded INITVALUE over the payload.
//  1) frame 0x00000001,0x00000002,CRC(good), o_rdy=1 -> out 0x1 (eop=0), 0x2 (eop=1, err=0); CRC never output.
//  2) same frame with CRC^32'h1 -> 0x2 emitted with o_eop=1, o_err=1; err_cnt=1 with macro, 0 without.
//  3) lone eop dword 0xDEADBEEF -> no o_val, runt=1 for one cycle; next good frame checks clean (seed reloaded).
//  4) 8-dword good frame, o_rdy toggling 1010 and i_val gaps -> payload order/values intact, held outputs stable, err=0.
//  5) reset_n low after 3 payload dwords, then good 2-dword frame -> no output from aborted frame, new frame err=0.
//  6) two good frames back-to-back, o_rdy=1 -> i_rdy=0 exactly one cycle (LAST) between frames, both err=0.

Source files
------------

// File: rtl/sata_crc_checker.sv
// SATA receive CRC checker: strips the trailing CRC dword, forwards payload and flags a CRC mismatch on the last payload dword.
// Optional SATA_CRC_ERRCNT_EN adds a saturating count of frames delivered with a CRC error.

`ifndef CRC_POLYNOMIAL
`define CRC_POLYNOMIAL 32'h04C11DB7
`endif
`ifndef CRC_INITVALUE
`define CRC_INITVALUE 32'h52325032
`endif

// One dword of MSB-first, non-reflected CRC-32 update.
module crc_calculator #(
    parameter logic [31:0] POLYNOMIAL = `CRC_POLYNOMIAL
) (
    input  logic [31:0] dat_i,
    input  logic [31:0] crc_i,
    output logic [31:0] crc_o
);
    always_comb begin
        crc_o = crc_i;
        for (int i = 31; i >= 0; i--) begin
            crc_o = {crc_o[30:0], 1'b0} ^ ({32{crc_o[31] ^ dat_i[i]}} & POLYNOMIAL);
        end
    end
endmodule

module sata_crc_checker #(
    parameter logic [31:0] POLYNOMIAL = `CRC_POLYNOMIAL,
    parameter logic [31:0] INITVALUE  = `CRC_INITVALUE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] i_dat,
    input  logic        i_val,
    input  logic        i_eop,
    output logic        i_rdy,
    output logic [31:0] o_dat,
    output logic        o_val,
    output logic        o_eop,
    output logic        o_err,
    input  logic        o_rdy,
    output logic        runt,
    output logic [15:0] err_cnt
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_LAST  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   hold_dat_q, hold_dat_d;
    logic            hold_err_q, hold_err_d;
    logic [DW-1:0]   crc_q, crc_d;
    logic            runt_q, runt_d;
    logic [DW-1:0]   crc_new;

    crc_calculator #(
        .POLYNOMIAL(POLYNOMIAL)
    ) u_crc (
        .dat_i(hold_dat_q),
        .crc_i(crc_q),
        .crc_o(crc_new)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_EMPTY;
            hold_dat_q <= '0;
            hold_err_q <= 1'b0;
            crc_q      <= INITVALUE;
            runt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_dat_q <= hold_dat_d;
            hold_err_q <= hold_err_d;
            crc_q      <= crc_d;
            runt_q     <= runt_d;
        end
    end

    // The held dword is only released once its successor shows whether it was the last payload dword.
    always_comb begin
        state_d    = state_q;
        hold_dat_d = hold_dat_q;
        hold_err_d = hold_err_q;
        crc_d      = crc_q;
        runt_d     = 1'b0;
        i_rdy      = 1'b1;
        o_val      = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                if (i_val && !i_eop) begin
                    hold_dat_d = i_dat;
                    state_d    = S_HOLD;
                end else if (i_val && i_eop) begin
                    runt_d = 1'b1;
                end
            end
            S_HOLD: begin
                o_val = i_val && !i_eop;
                i_rdy = i_eop ? 1'b1 : o_rdy;
                if (i_val && !i_eop && o_rdy) begin
                    crc_d      = crc_new;
                    hold_dat_d = i_dat;
                end else if (i_val && i_eop) begin
                    hold_err_d = (crc_new != i_dat);
                    crc_d      = INITVALUE;
                    state_d    = S_LAST;
                end
            end
            S_LAST: begin
                o_val = 1'b1;
                i_rdy = 1'b0;
                if (o_rdy) begin
                    hold_err_d = 1'b0;
                    state_d    = S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    assign o_dat = hold_dat_q;
    assign o_eop = (state_q == S_LAST);
    assign o_err = hold_err_q;
    assign runt  = runt_q;

`ifdef SATA_CRC_ERRCNT_EN
    logic [CW-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (o_val && o_rdy && o_eop && o_err && (err_cnt_q != {CW{1'b1}})) begin
            err_cnt_d = err_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = CW'(0);
`endif
endmodule
